// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM encodings and the reset PC.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pcseq_state_t;

    localparam logic [31:0] PCSEQ_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_perf_counter.sv
// Free-running performance counter with enable; wraps silently at 2^WIDTH.
module pc_sequencer_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: steps PC by 4, applies E-stage redirects, and parks a redirect
// that resolves under stall until the stall releases. Also counts branches.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(PCSEQ_RESET_PC),
    parameter int                  CNT_WIDTH = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Stall,
    input  logic                 ValidE,
    input  logic                 IsBranchE,
    input  logic                 BranchE,
    input  logic [PC_WIDTH-1:0]  BranchTargetE,
    input  logic                 JumpE,
    input  logic [PC_WIDTH-1:0]  JumpTargetE,
    output logic [PC_WIDTH-1:0]  PCF,
    output logic                 FetchEn,
    output logic                 RedirectPending,
    output logic [CNT_WIDTH-1:0] BranchCount,
    output logic [CNT_WIDTH-1:0] TakenCount,
    output pcseq_state_t         DbgState
);

    pcseq_state_t        r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_pend_target;
    logic                r_pend_branch;
    logic                r_pend_taken;
    logic                r_redirect_pending;

    logic                w_redir;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_run;
    logic                w_hold;
    logic                w_branch_inc;
    logic                w_taken_inc;

    // Jump wins over a simultaneous branch (an illegal encoding, but deterministic).
    assign w_redir  = ValidE & (JumpE | (IsBranchE & BranchE));
    assign w_target = JumpE ? JumpTargetE : BranchTargetE;
    assign w_run    = (r_state == ST_RUN);
    assign w_hold   = (r_state == ST_HOLD);

    // A branch retires on the cycle E advances; in HOLD the captured flags stand in
    // for the re-presented E inputs, so a stalled branch counts exactly once.
    assign w_branch_inc = ~Stall & ((w_run & ValidE & IsBranchE) | (w_hold & r_pend_branch));
    assign w_taken_inc  = ~Stall & ((w_run & ValidE & IsBranchE & BranchE) |
                                    (w_hold & r_pend_taken));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state            <= ST_BOOT;
            r_pc               <= RESET_PC;
            r_pend_target      <= '0;
            r_pend_branch      <= 1'b0;
            r_pend_taken       <= 1'b0;
            r_redirect_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!Stall) begin
                        r_pc <= w_redir ? w_target : r_pc + PC_WIDTH'(4);
                    end else if (w_redir) begin
                        r_pend_target      <= w_target;
                        r_pend_branch      <= IsBranchE;
                        r_pend_taken       <= IsBranchE & BranchE;
                        r_redirect_pending <= 1'b1;
                        r_state            <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!Stall) begin
                        r_pc               <= r_pend_target;
                        r_redirect_pending <= 1'b0;
                        r_state            <= ST_RUN;
                    end
                end
                default: begin
                    r_state            <= ST_BOOT;
                    r_redirect_pending <= 1'b0;
                end
            endcase
        end
    end

    pc_sequencer_perf_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_en    (w_branch_inc),
        .o_count (BranchCount)
    );

    pc_sequencer_perf_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_en    (w_taken_inc),
        .o_count (TakenCount)
    );

    assign PCF             = r_pc;
    assign RedirectPending = r_redirect_pending;
    assign FetchEn         = w_run & ~Stall;
    assign DbgState        = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, redirects, stalled redirects, reset in HOLD, wraps.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        ValidE;
    logic        IsBranchE;
    logic        BranchE;
    logic [31:0] BranchTargetE;
    logic        JumpE;
    logic [31:0] JumpTargetE;

    logic [31:0]  PCF, PCF4;
    logic         FetchEn, FetchEn4;
    logic         RedirectPending, RedirectPending4;
    logic [31:0]  BranchCount, TakenCount;
    logic [3:0]   BranchCount4, TakenCount4;
    pcseq_state_t DbgState, DbgState4;

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .ValidE(ValidE),
        .IsBranchE(IsBranchE), .BranchE(BranchE), .BranchTargetE(BranchTargetE),
        .JumpE(JumpE), .JumpTargetE(JumpTargetE), .PCF(PCF), .FetchEn(FetchEn),
        .RedirectPending(RedirectPending), .BranchCount(BranchCount),
        .TakenCount(TakenCount), .DbgState(DbgState)
    );

    pc_sequencer #(.CNT_WIDTH(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .ValidE(ValidE),
        .IsBranchE(IsBranchE), .BranchE(BranchE), .BranchTargetE(BranchTargetE),
        .JumpE(JumpE), .JumpTargetE(JumpTargetE), .PCF(PCF4), .FetchEn(FetchEn4),
        .RedirectPending(RedirectPending4), .BranchCount(BranchCount4),
        .TakenCount(TakenCount4), .DbgState(DbgState4)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic valid, input logic isbr,
                         input logic br, input logic [31:0] btgt,
                         input logic jmp, input logic [31:0] jtgt);
        Stall         = stall;
        ValidE        = valid;
        IsBranchE     = isbr;
        BranchE       = br;
        BranchTargetE = btgt;
        JumpE         = jmp;
        JumpTargetE   = jtgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_core(input string tag, input logic [31:0] pc, input logic [1:0] st,
                            input logic rp, input logic [31:0] bc, input logic [31:0] tc);
        chk({tag, ".pc"}, PCF, pc);
        chk({tag, ".state"}, 32'(DbgState), 32'(st));
        chk({tag, ".pend"}, 32'(RedirectPending), 32'(rp));
        chk({tag, ".bcnt"}, BranchCount, bc);
        chk({tag, ".tcnt"}, TakenCount, tc);
    endtask

    initial begin
        // Reset with junk on the E inputs: reset must dominate.
        Reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 1'b1, 32'h0000_0DEF);
        tick();
        chk_core("reset", 32'h0, 2'd0, 1'b0, 32'd0, 32'd0);
        chk("reset.fetch_en", 32'(FetchEn), 32'd0);

        // BOOT ignores stall and a taken branch, and moves to RUN with PCF unchanged.
        Reset = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 1'b0, 32'h0);
        chk("boot.fetch_en", 32'(FetchEn), 32'd0);
        tick();
        chk_core("boot_exit", 32'h0, 2'd1, 1'b0, 32'd0, 32'd0);
        idle();
        #1;
        chk("run.fetch_en", 32'(FetchEn), 32'd1);

        // Sequential fetch: 4, 8, ... up to 0x20.
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("seq.pc", PCF, 32'(4 * i));
        end
        chk("seq.bcnt", BranchCount, 32'd0);

        // Taken branch at 0x20 -> 0x100.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        tick();
        chk_core("taken", 32'h100, 2'd1, 1'b0, 32'd1, 32'd1);

        // Not-taken branch at 0x100 -> 0x104.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0900, 1'b0, 32'h0);
        tick();
        chk_core("not_taken", 32'h104, 2'd1, 1'b0, 32'd2, 32'd1);

        // Taken branch to 0x200 resolving under a 3-cycle stall.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        #1;
        chk("stall_run.fetch_en", 32'(FetchEn), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_core("hold", 32'h104, 2'd2, 1'b1, 32'd2, 32'd1);
            chk("hold.fetch_en", 32'(FetchEn), 32'd0);
            // Garbage on E while holding must be ignored.
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_DEAD, 1'b0, 32'h0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_DEAD, 1'b0, 32'h0);
        tick();
        chk_core("hold_exit", 32'h200, 2'd1, 1'b0, 32'd3, 32'd2);
        idle();
        tick();
        chk_core("after_hold", 32'h204, 2'd1, 1'b0, 32'd3, 32'd2);

        // Not-taken branch stalled 2 cycles: counted once on release.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0900, 1'b0, 32'h0);
        tick();
        tick();
        chk_core("stall_nt", 32'h204, 2'd1, 1'b0, 32'd3, 32'd2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0900, 1'b0, 32'h0);
        tick();
        chk_core("stall_nt_rel", 32'h208, 2'd1, 1'b0, 32'd4, 32'd2);

        // Jump overlapping a taken branch: jump target wins, no count.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0400);
        tick();
        chk_core("jump", 32'h400, 2'd1, 1'b0, 32'd4, 32'd2);

        // Bubble carrying a taken branch: no redirect, no count.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        tick();
        chk_core("bubble", 32'h404, 2'd1, 1'b0, 32'd4, 32'd2);

        // Unaligned target passes through untouched.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0123);
        tick();
        chk("unaligned.pc", PCF, 32'h123);
        idle();
        tick();
        chk("unaligned_inc.pc", PCF, 32'h127);

        // PC wrap at the top of the address space.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pre.pc", PCF, 32'hFFFF_FFFC);
        idle();
        tick();
        chk("wrap.pc", PCF, 32'h0);

        // Enter HOLD with target 0x500, then reset: the redirect is discarded.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'h0);
        tick();
        chk_core("hold500", 32'h0, 2'd2, 1'b1, 32'd4, 32'd2);
        Reset = 1'b1;
        idle();
        tick();
        chk_core("reset_hold", 32'h0, 2'd0, 1'b0, 32'd0, 32'd0);
        Reset = 1'b0;
        tick();
        chk_core("reboot", 32'h0, 2'd1, 1'b0, 32'd0, 32'd0);
        tick();
        chk("reboot_inc.pc", PCF, 32'h4);

        // Counter wrap on the 4-bit instance: 15 branches, then one more.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("cnt4_pre.bcnt", 32'(BranchCount4), 32'd15);
        chk("cnt32_pre.bcnt", BranchCount, 32'd15);
        tick();
        chk("cnt4_wrap.bcnt", 32'(BranchCount4), 32'd0);
        chk("cnt4_wrap.tcnt", 32'(TakenCount4), 32'd0);
        chk("cnt32_nowrap.bcnt", BranchCount, 32'd16);
        chk("cnt_wrap.pc", PCF, 32'h44);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch-stage PC register of the 3-stage pipeline.
- Applies redirects from execute-stage branch/jump resolution to the PC, driven by the BranchControl decision.
- Holds a redirect that resolves while the pipeline is stalled, and applies it exactly once when the stall releases.
- Counts resolved and taken branches for performance reporting.
- Sits between BranchControl/decode in E and the instruction memory address port in F. The architectural delay slot is preserved, so no fetch flush is generated.

Parameters:
- PC_WIDTH, 32, width of PC and target buses
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- CNT_WIDTH, 32, width of performance counters

Ports:
- Clock  in  1  system clock, rising-edge
- Reset  in  1  synchronous, active-high reset
- Stall  in  1  pipeline stall; high freezes F/E registers
- ValidE  in  1  E-stage instruction is valid (not a bubble)
- IsBranchE  in  1  E-stage instruction is a conditional branch
- BranchE  in  1  branch-taken decision from BranchControl
- BranchTargetE  in  PC_WIDTH  E-stage branch target
- JumpE  in  1  E-stage J/JAL/JR/JALR
- JumpTargetE  in  PC_WIDTH  E-stage jump target
- PCF  out  PC_WIDTH  fetch address
- FetchEn  out  1  instruction memory read enable
- RedirectPending  out  1  high while in HOLD
- BranchCount  out  CNT_WIDTH  resolved conditional branches
- TakenCount  out  CNT_WIDTH  taken conditional branches

Behaviour:
Reset (synchronous, active-high):
- Reset sampled high at a rising edge gives: PCF=RESET_PC, state=BOOT, FetchEn=0, RedirectPending=0, both counters=0, pending target=0.
- Reset dominates all other inputs.
- Reset mid-HOLD discards the pending redirect.

Redirect request (combinational):
- redir = ValidE & (JumpE | (IsBranchE & BranchE)).
- Target mux: JumpE=1 selects JumpTargetE; otherwise BranchTargetE. Jump wins if both are asserted, which is an illegal encoding.

States:
- BOOT:
  - FetchEn=0, PCF holds RESET_PC.
  - Next cycle goes to RUN unconditionally, regardless of Stall.
  - Inputs are ignored.
- RUN:
  - FetchEn=~Stall.
  - Stall=0, redir=0: PCF <= PCF+4.
  - Stall=0, redir=1: PCF <= target. This is single-cycle: the delay-slot instruction is the one fetched concurrently.
  - Stall=1, redir=0: PCF holds.
  - Stall=1, redir=1: capture target into the pending register, PCF holds, go to HOLD.
- HOLD:
  - RedirectPending=1, FetchEn=0.
  - All E inputs are ignored, since the same stalled E instruction is re-presented.
  - Stall=1: remain in HOLD.
  - Stall=0: PCF <= pending target, go to RUN. The redirect is applied exactly once.

Arithmetic:
- PC+4 is modulo 2^PC_WIDTH; 32'hFFFF_FFFC wraps to 0.
- Targets are used as given. No alignment check is made; bits [1:0] pass through.

Counters:
- Increment only when an E instruction retires, i.e. ValidE & IsBranchE & ~Stall in RUN.
- An instruction stalled for N cycles counts once, on the cycle its stall releases. The HOLD exit cycle counts it; in HOLD, the count uses the captured taken flag.
- TakenCount additionally requires BranchE, or the captured flag in HOLD.
- Both counters wrap at 2^CNT_WIDTH with no saturation.
- Jumps are never counted.

Outputs:
- All outputs are registered except FetchEn, which is a decode of state and Stall.

Decomposition:
- Shared package/header (alongside Opcode.vh), new PCSeq.vh:
  - State encodings: BOOT=2'd0, RUN=2'd1, HOLD=2'd2.
  - RESET_PC default.
- One natural sub-module, perf_counter: a CNT_WIDTH enable/wrap counter, instantiated twice.
- The FSM, PC register and pending register stay in pc_sequencer.

Test Plan:
1. Reset, then release:
   - Cycle 1: PCF=0, FetchEn=0.
   - Then PCF = 0, 4, 8, 12 on successive cycles.
   - Counters stay 0.
2. In RUN, PCF=0x20; ValidE=1, IsBranchE=1, BranchE=1, BranchTargetE=0x100, Stall=0:
   - Next PCF=0x100.
   - BranchCount=1, TakenCount=1.
   - With BranchE=0 instead: PCF=0x24, BranchCount=1, TakenCount=0.
3. Taken branch to 0x200 arrives with Stall=1 held for 3 cycles:
   - PCF frozen; RedirectPending=1 for 3 cycles; FetchEn=0.
   - Cycle after Stall falls: PCF=0x200, RedirectPending=0.
   - BranchCount and TakenCount each +1 exactly once.
4. JumpE=1 with JumpTargetE=0x400, together with a taken branch to 0x300 (illegal overlap):
   - PCF=0x400.
   - Counters unchanged if IsBranchE=0.
5. Reset asserted mid-HOLD (pending target 0x500):
   - Next cycle PCF=0, state BOOT, RedirectPending=0, counters 0.
   - 0x500 is never fetched.
6. Wrap cases:
   - PCF=0xFFFF_FFFC, no redirect: PCF=0.
   - BranchCount preset via 2^CNT_WIDTH−1 increments (CNT_WIDTH=4 instance), then one more: BranchCount=0.
